// File: rtl/axi_stream_pkt_src.sv
// axi_stream_pkt_src
//   Deterministic valid/ready packet source. Emits packets of incrementing
//   data with a last-beat marker, honours backpressure, and inserts a fixed
//   number of idle cycles after each accepted beat. The data counter is never
//   cleared between runs, so a receiver can detect lost or duplicated beats.
//
// Ports
//   aclk_i     : clock, rising edge
//   areset_i   : asynchronous active-high reset
//   start_i    : start pulse, honoured only while idle
//   len_i      : beats per packet minus one (sampled at start)
//   gap_i      : idle cycles after each accepted beat (sampled at start)
//   npkt_i     : packets per run, 0 = run until stop (sampled at start)
//   stop_i     : request the run to end at the next packet boundary
//   ready_i    : downstream ready
//   valid_o    : beat valid
//   data_o     : beat payload
//   last_o     : final beat of the packet
//   busy_o     : a run is in progress
//   done_o     : one-cycle pulse when a run ends
//   pkt_cnt_o  : packets completed in the current/last run
module axi_stream_pkt_src #(
  parameter int                 DWIDTH = 8,
  parameter int                 LEN_W  = 8,
  parameter int                 GAP_W  = 4,
  parameter logic [DWIDTH-1:0]  SEED   = '0
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic [LEN_W-1:0]  npkt_i,
  input  logic              stop_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  pkt_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t            state_q,     state_d;
  logic [DWIDTH-1:0] data_q,      data_d;
  logic [LEN_W-1:0]  beat_idx_q,  beat_idx_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [GAP_W-1:0]  gap_q,       gap_d;
  logic [LEN_W-1:0]  npkt_q,      npkt_d;
  logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
  logic [LEN_W-1:0]  pkt_cnt_q,   pkt_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              valid_q,     valid_d;
  logic              last_q,      last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  logic [LEN_W-1:0]  beat_inc;
  logic [LEN_W-1:0]  pkt_inc;

  assign beat_inc = beat_idx_q + 1'b1;
  assign pkt_inc  = pkt_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    beat_idx_d  = beat_idx_q;
    len_d       = len_q;
    gap_d       = gap_q;
    npkt_d      = npkt_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    stop_pend_d = stop_pend_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d       = len_i;
          gap_d       = gap_i;
          npkt_d      = npkt_i;
          beat_idx_d  = '0;
          pkt_cnt_d   = '0;
          stop_pend_d = 1'b0;
          busy_d      = 1'b1;
          valid_d     = 1'b1;
          last_d      = (len_i == '0);
          state_d     = S_SEND;
        end
      end

      S_SEND: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (valid_q && ready_i) begin
          data_d = data_q + 1'b1;
          if (last_q) begin
            beat_idx_d = '0;
            pkt_cnt_d  = pkt_inc;
            // A stop arriving in the same cycle as the last beat still ends the run.
            if (((npkt_q != '0) && (pkt_inc == npkt_q)) || stop_pend_q || stop_i) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else if (gap_q != '0) begin
              valid_d   = 1'b0;
              last_d    = 1'b0;
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end else begin
              last_d = (len_q == '0);
            end
          end else begin
            beat_idx_d = beat_inc;
            if (gap_q != '0) begin
              valid_d   = 1'b0;
              last_d    = 1'b0;
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end else begin
              last_d = (beat_inc == len_q);
            end
          end
        end
      end

      S_GAP: begin
        if (stop_i) stop_pend_d = 1'b1;
        // Counter starts at gap and leaves on 1, giving exactly gap idle cycles.
        if (gap_cnt_q == GAP_W'(1)) begin
          valid_d = 1'b1;
          last_d  = (beat_idx_q == len_q);
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q     <= S_IDLE;
      data_q      <= SEED;
      beat_idx_q  <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      npkt_q      <= '0;
      gap_cnt_q   <= '0;
      pkt_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      beat_idx_q  <= beat_idx_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      npkt_q      <= npkt_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stop_pend_q <= stop_pend_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign last_o    = last_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_axi_stream_pkt_src.sv
module tb_axi_stream_pkt_src;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int GW = 4;
  localparam logic [DW-1:0] SEED_V = 8'hFE;

  logic          aclk_i = 1'b0;
  logic          areset_i;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic [GW-1:0] gap_i;
  logic [LW-1:0] npkt_i;
  logic          stop_i;
  logic          ready_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  logic [LW-1:0] pkt_cnt_o;

  axi_stream_pkt_src #(.DWIDTH(DW), .LEN_W(LW), .GAP_W(GW), .SEED(SEED_V)) dut (
    .aclk_i(aclk_i), .areset_i(areset_i), .start_i(start_i), .len_i(len_i),
    .gap_i(gap_i), .npkt_i(npkt_i), .stop_i(stop_i), .ready_i(ready_i),
    .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 aclk_i = ~aclk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a run is a stream of beats; beat k of a packet is
  // last when k == len; after each accepted non-final beat the source idles
  // for gap cycles; the run ends on a last beat once npkt packets are done
  // or a stop has been requested.
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_pkt;
  int            m_len, m_gap, m_npkt, m_beat, m_idle, m_acc;
  bit            m_busy, m_done, m_stop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = SEED_V; m_pkt = '0; m_len = 0; m_gap = 0; m_npkt = 0;
    m_beat = 0; m_idle = 0; m_acc = 0; m_busy = 0; m_done = 0; m_stop = 0;
  endtask

  task automatic model_edge(input bit rdy, input bit st, input bit stp);
    bit ev;
    ev = m_busy && (m_idle == 0);
    m_done = 0;
    if (!m_busy) begin
      if (st) begin
        m_len = int'(len_i); m_gap = int'(gap_i); m_npkt = int'(npkt_i);
        m_busy = 1; m_beat = 0; m_pkt = '0; m_stop = 0; m_idle = 0; m_acc = 0;
      end
    end else begin
      if (ev && rdy) begin
        m_data++;
        m_acc++;
        if (m_beat == m_len) begin
          m_beat = 0;
          m_pkt++;
          if ((m_npkt != 0 && int'(m_pkt) == m_npkt) || m_stop || stp) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_idle = m_gap;
          end
        end else begin
          m_beat++;
          m_idle = m_gap;
        end
      end else if (m_idle > 0) begin
        m_idle--;
      end
      if (stp) m_stop = 1;
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = m_busy && (m_idle == 0);
    check("valid",   32'(valid_o),   32'(ev));
    check("data",    32'(data_o),    32'(m_data));
    check("last",    32'(last_o),    32'(ev && (m_beat == m_len)));
    check("busy",    32'(busy_o),    32'(m_busy));
    check("done",    32'(done_o),    32'(m_done));
    check("pkt_cnt", 32'(pkt_cnt_o), 32'(m_pkt));
  endtask

  // Drive inputs at the falling edge, update the model at the rising edge,
  // then compare at the next falling edge.
  task automatic step(input bit rdy, input bit st, input bit stp);
    ready_i = rdy; start_i = st; stop_i = stp;
    @(posedge aclk_i);
    model_edge(rdy, st, stp);
    @(negedge aclk_i);
    check_outputs();
  endtask

  task automatic run(input int len, input int gap, input int npkt, input int stop_at,
                     input int rdy_pct, input int bp, input bit junk_start);
    int  cyc;
    int  bp_left;
    bit  stop_sent;
    cyc = 0; bp_left = bp; stop_sent = 0;
    len_i = 8'(len); gap_i = 4'(gap); npkt_i = 8'(npkt);
    step(1'b0, 1'b1, 1'b0);
    while (m_busy && cyc < 2000) begin
      bit r, s, st;
      if (bp_left > 0) begin
        r = 0;
        bp_left--;
      end else begin
        r = ($urandom_range(99) < rdy_pct);
      end
      s = 0;
      if (stop_at >= 0 && !stop_sent && m_acc == stop_at) begin
        s = 1;
        stop_sent = 1;
      end
      st = 0;
      if (junk_start && $urandom_range(7) == 0) begin
        st = 1;
        len_i = 8'($urandom); gap_i = 4'($urandom); npkt_i = 8'($urandom);
      end
      step(r, st, s);
      cyc++;
    end
    check("run_ended", 32'(busy_o), 32'(0));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    areset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b0;
    len_i = '0; gap_i = '0; npkt_i = '0;
    model_reset();
    repeat (2) @(negedge aclk_i);
    areset_i = 1'b0;
    check_outputs();
    step(1'b1, 1'b0, 1'b1);  // stop in idle has no effect

    // Wrap: FE FF 00 01, with stray start pulses while busy.
    run(3, 0, 1, -1, 100, 0, 1'b1);
    check("wrap_next_data", 32'(data_o), 32'(8'h02));

    // Continuous flow, two packets of four, one beat per cycle.
    run(3, 0, 2, -1, 100, 0, 1'b0);
    check("flow_pkt_cnt", 32'(pkt_cnt_o), 32'(2));
    check("flow_data", 32'(data_o), 32'(8'h0A));

    // Backpressure for five cycles after valid rises.
    run(1, 0, 1, -1, 100, 5, 1'b0);
    check("bp_data", 32'(data_o), 32'(8'h0C));

    // Gap of three idle cycles between beats.
    run(2, 3, 2, -1, 100, 0, 1'b0);

    // Stop during beat 2 of packet 3 in an unbounded run.
    run(3, 0, 0, 9, 100, 0, 1'b0);
    check("stop_pkt_cnt", 32'(pkt_cnt_o), 32'(3));

    // len=0: every beat is last.
    run(0, 1, 3, -1, 70, 0, 1'b0);

    // Randomized runs.
    for (int i = 0; i < 10; i++) begin
      int sa;
      sa = ($urandom_range(3) == 0) ? int'($urandom_range(6)) : -1;
      run(int'($urandom_range(4)), int'($urandom_range(3)), int'($urandom_range(3, 1)),
          sa, int'($urandom_range(100, 40)), 0, 1'b1);
    end
    run(int'($urandom_range(3)), int'($urandom_range(2)), 0, int'($urandom_range(12)),
        int'($urandom_range(100, 50)), 0, 1'b0);

    // Reset mid-packet with ready low.
    len_i = 8'd3; gap_i = '0; npkt_i = 8'd1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2 areset_i = 1'b1;
    #1;
    check("rst_async_valid", 32'(valid_o), 32'(0));
    check("rst_async_busy",  32'(busy_o),  32'(0));
    check("rst_async_data",  32'(data_o),  32'(SEED_V));
    model_reset();
    @(negedge aclk_i);
    areset_i = 1'b0;
    check_outputs();
    step(1'b1, 1'b0, 1'b0);
    run(1, 0, 2, -1, 80, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_pkt_src.md
Name: axi_stream_pkt_src

Overview:
- Valid/ready stream transmitter. Drives packets of incrementing data, with a last-beat marker, into the upstream port of the stream register slice.
- Programmable packet length, inter-beat gap and packet count.
- Strictly honours backpressure, so it replaces the random bench driver as a deterministic, checkable stimulus source.
- The data sequence is continuous across runs, so a downstream receiver can check for lost or duplicated beats.

Parameters:
DWIDTH, 8, data width
LEN_W, 8, width of len_i, npkt_i, pkt_cnt_o
GAP_W, 4, width of gap_i
SEED, 0, data_o value after reset (DWIDTH bits)

Ports:
aclk_i  in  1  clock, all logic on rising edge
areset_i  in  1  reset, asynchronous, active-high
start_i  in  1  start pulse; accepted only when busy_o=0
len_i  in  LEN_W  beats per packet minus 1; sampled at start
gap_i  in  GAP_W  idle cycles after each accepted beat; sampled at start
npkt_i  in  LEN_W  packets per run; 0 = run until stop; sampled at start
stop_i  in  1  pulse; request stop at next packet boundary
ready_i  in  1  downstream ready
valid_o  out  1  data valid
data_o  out  DWIDTH  payload
last_o  out  1  final beat of packet
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse when a run ends
pkt_cnt_o  out  LEN_W  packets completed in current/last run

Behaviour:
- Reset (async assert, sync release):
  - valid_o=0, data_o=SEED, last_o=0, busy_o=0, done_o=0, pkt_cnt_o=0.
  - State IDLE; stop_pending=0.
  - Reset mid-packet drops valid_o immediately; no beat completes.
- All outputs are registered. valid_o has no combinational path from ready_i.
- Handshake is valid_o & ready_i on a rising edge.
- Once valid_o=1, valid_o, data_o and last_o hold unchanged until the handshake.
- States: IDLE, SEND, GAP.
- IDLE:
  - start_i=1 captures len_i, gap_i, npkt_i.
  - Clears beat_idx, pkt_cnt_o and stop_pending; sets busy_o=1.
  - Next state SEND. valid_o rises the cycle after start (latency 1).
- SEND: valid_o=1; last_o=(beat_idx==len).
- On handshake in SEND:
  - data_o <= data_o+1 (mod 2^DWIDTH, wraps FF->00).
  - If not last: beat_idx++.
  - If last: beat_idx<=0 and pkt_cnt_o++ (wraps when npkt=0).
  - Run ends if last and (pkt_cnt_o+1==npkt, npkt!=0, or stop_pending / stop_i this cycle):
    - Next state IDLE, valid_o<=0, last_o<=0, busy_o<=0, done_o<=1 for one cycle.
  - Otherwise, if gap!=0: next state GAP, valid_o<=0, gap counter<=gap.
  - Otherwise: stay in SEND with valid_o held at 1 (one beat per cycle when ready_i=1).
- GAP:
  - valid_o=0; counter decrements each cycle.
  - When it reaches 1, next state SEND (exactly gap idle cycles).
  - Gap cycles are not extended or shortened by ready_i.
- stop_i:
  - Sets stop_pending while busy_o=1.
  - The current packet always completes through its last beat; the run then ends.
  - Ignored in IDLE.
- start_i while busy_o=1: ignored, no reload.
- len=0: every beat has last_o=1.
- npkt=1: single packet.
- data_o is not reset between runs. The next run continues from the last value +1.
- pkt_cnt_o holds its final value in IDLE until the next start.

Test Plan:
- Continuous flow: len=3, gap=0, npkt=2, ready_i=1 → data SEED..SEED+7 on 8 consecutive cycles; last_o on beats 4 and 8; done_o 1 cycle after beat 8; pkt_cnt_o=2.
- Backpressure: len=1, npkt=1, ready_i low for 5 cycles after valid_o rises → valid_o/data_o/last_o stable for all 5 cycles; 2 beats total; no duplicate or skip.
- Gap: len=2, gap=3, ready_i=1 → exactly 3 cycles of valid_o=0 between every accepted beat; data sequence unbroken.
- Stop: npkt=0, len=3, stop_i pulse on beat 2 of packet 3 → beats 3 and 4 still sent; run ends after last_o of packet 3; pkt_cnt_o=3; done_o pulse.
- Wrap/continuity: DWIDTH=8, SEED=8'hFE, len=3 → data FE, FF, 00, 01. Second run then starts at 02. start_i pulsed while busy has no effect.
- Reset mid-packet: assert areset_i asynchronously during SEND with ready_i=0 → valid_o=0 immediately; after release data_o=SEED, busy_o=0, state IDLE.
